ndf_epp_bridge: RTL
===================

// Module: ndf_epp_bridge
// PURPOSE
//  Parametrised EPP-to-NAND-flash bridge; successor to the fixed 10 MHz, 2-CE, 1-cycle-strobe VTerm datapath.
//  Host addresses a register via EPP address cycles, then EPP data cycles issue NAND command/address/data-write/read/busy ops.
//  Adds NUM_CE chip enables, programmable strobe widths, NAND data writes, WP control.
//  Sits between EPP pins and NAND pins.
// PARAMETERS
//  NUM_CE   2  number of NAND chip enables (1..8)
//  T_WP     1  clk10 cycles WE_n held low (>=1)
//  T_WH     1  clk10 cycles WE_n high, data/CLE/ALE held after rise (>=1)
//  T_RP     2  clk10 cycles RE_n low before ndf_io sampled (>=1)
//  TMO_W    16 busy-timeout counter width (used only with NDF_BUSY_TMO_EN)
// PORTS
//  clk10        in   1       single clock, all logic posedge
//  rst_n        in   1       async active-low reset
//  epp_astb_n   in   1       EPP address strobe (async; 2-flop synchronised inside)
//  epp_dstb_n   in   1       EPP data strobe (async; 2-flop synced)
//  epp_wr_n     in   1       EPP write (async; 2-flop synced)
//  epp_dq       inout 8      EPP data; driven with epp_q when synced epp_wr_n=1
//  epp_wait_n   out  1       EPP wait/ack
//  ndf_io       inout 8      NAND data; driven when ndf_re_n=1
//  ndf_ce_n     out  NUM_CE  NAND chip enables
//  ndf_cle      out  1       command latch enable
//  ndf_ale      out  1       address latch enable
//  ndf_we_n     out  1       write enable
//  ndf_re_n     out  1       read enable
//  ndf_wp_n     out  1       write protect
//  ndf_r_b_n    in   1       ready/busy_n (open drain)
// BEHAVIOUR
//  Reset: epp_wait_n=0, ndf_ce_n=all 1, cle=ale=0, we_n=re_n=1, wp_n=0, epp_q=0, curad=0, state IDLE.
//  EPP addr write (astb_n_s=0, wr_n_s=0) latches curad<=epp_d_s every cycle; ack epp_wait_n=1 until astb_n_s=1.
//  IDLE: on dstb_n_s=0 -> DISPATCH. DISPATCH decodes {wr_n_s, curad}:
//   wr 'C'/'A'/'W' -> WE_LO with cle/ale/neither; ndf_io_w<=epp_d_s.
//   rd 'D' -> RE_LO; rd 'B' -> BUSY; wr 'E' -> ce_n<=~epp_d_s[NUM_CE-1:0], ACK;
//   wr 'P' -> wp_n<=epp_d_s[0], ACK; any other -> ACK (no NAND activity, epp_q=0xFF on read).
//  WE_LO: we_n=0 for T_WP cycles -> WE_HI: we_n=1, io/cle/ale held T_WH cycles -> ACK.
//  RE_LO: re_n=0 T_RP cycles; on last, epp_q<=ndf_io -> ACK with re_n still 0 until dstb_n_s=1.
//  BUSY: epp_q={8{r_b_n_s}}; epp_wait_n=r_b_n_s; ends ACK path when dstb_n_s=1.
//  ACK: epp_wait_n=1; dstb_n_s=1 -> IDLE (re_n returns 1, cle/ale 0). One op per strobe.
//  Strobe widths via one down-counter sized clog2(max(T_WP,T_WH,T_RP))+1; loaded on state entry.
//  Simultaneous astb/dstb low: astb wins; state stays IDLE.
//  dstb released mid WE/RE sequence: sequence completes (NAND timing honoured), then ACK sees dstb high -> IDLE.
//  ndf_r_b_n 2-flop synced. Reset mid-op: all outputs to reset values immediately.
//  Pin-facing outputs registered; no combinational path from EPP pins to NAND pins.
// CONFIGURATION
//  NDF_BUSY_TMO_EN defined: BUSY counts cycles (TMO_W bits, saturating); at all-ones with r_b_n_s=0,
//   epp_q<=8'hEE, epp_wait_n=1 -> ACK; counter clears on BUSY entry.
//  Undefined: BUSY waits for ready indefinitely; no counter logic.
// STRUCTURE
//  Package ndf_pkg: state enum (IDLE,DISPATCH,WE_LO,WE_HI,RE_LO,BUSY,ACK), register codes
//   REG_ADDR=8'h41, REG_CMD=8'h43, REG_DATA=8'h44, REG_BUSY=8'h42, REG_CE=8'h45,
//   REG_WDATA=8'h57, REG_WP=8'h50, TMO_CODE=8'hEE.
//  One sub-module: epp_sync (2-flop synchroniser for strobes, wr_n, data, r_b_n; async reset to 1s/0s).
// TESTING
//  Addr 'C', data-write 0x90, T_WP=2, T_WH=1 -> cle=1, we_n low exactly 2 cycles, ndf_io=0x90 at rise, wait_n=1.
//  Addr 'E' write 0x04 (NUM_CE=4) -> ndf_ce_n=4'b1011; addr 'P' write 0x01 -> wp_n=1.
//  Addr 'D' read, NAND model drives 0xEC, T_RP=3 -> re_n low >=3 cycles, epp_dq=0xEC when wait_n rises.
//  Addr 'B' read, r_b_n low 50 cycles then high -> wait_n stays 0 then 1, epp_dq=0xFF.
//  NDF_BUSY_TMO_EN, TMO_W=4, r_b_n stuck low -> ACK after 15 cycles with epp_dq=0xEE.
//  Assert rst_n mid WE_LO -> we_n=1, ce_n all 1, state IDLE; next op runs normally.

Source files
------------

// File: rtl/ndf_pkg.sv
// Shared definitions for the EPP-to-NAND bridge: FSM states, EPP register codes and a sizing helper.
package ndf_pkg;

   typedef enum logic [2:0] {
      IDLE,
      DISPATCH,
      WE_LO,
      WE_HI,
      RE_LO,
      BUSY,
      ACK
   } state_t;

   localparam logic [7:0] REG_ADDR  = 8'h41;
   localparam logic [7:0] REG_BUSY  = 8'h42;
   localparam logic [7:0] REG_CMD   = 8'h43;
   localparam logic [7:0] REG_DATA  = 8'h44;
   localparam logic [7:0] REG_CE    = 8'h45;
   localparam logic [7:0] REG_WP    = 8'h50;
   localparam logic [7:0] REG_WDATA = 8'h57;
   localparam logic [7:0] TMO_CODE  = 8'hEE;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/epp_sync.sv
// Two-flop synchronisers for the asynchronous EPP strobes, EPP data and NAND ready/busy.
// Active-low controls reset to 1 (inactive), data resets to 0.
module epp_sync (
   input  logic       clk10,
   input  logic       rst_n,
   input  logic       astb_n,
   input  logic       dstb_n,
   input  logic       wr_n,
   input  logic [7:0] d,
   input  logic       r_b_n,
   output logic       astb_n_s,
   output logic       dstb_n_s,
   output logic       wr_n_s,
   output logic [7:0] d_s,
   output logic       r_b_n_s
);

   logic [3:0] ctl_q1;
   logic [3:0] ctl_q2;
   logic [7:0] d_q1;

   // NOTE: non-blocking assignments so each stage captures the value from before the edge.
   always_ff @(posedge clk10 or negedge rst_n) begin
      if (!rst_n) begin
         ctl_q1 <= 4'hF;
         ctl_q2 <= 4'hF;
         d_q1   <= 8'h00;
         d_s    <= 8'h00;
      end else begin
         ctl_q1 <= {astb_n, dstb_n, wr_n, r_b_n};
         ctl_q2 <= ctl_q1;
         d_q1   <= d;
         d_s    <= d_q1;
      end
   end

   assign {astb_n_s, dstb_n_s, wr_n_s, r_b_n_s} = ctl_q2;

endmodule

// File: rtl/ndf_epp_bridge.sv
// EPP-to-NAND-flash bridge: EPP address cycles select a register, data cycles run one NAND op each.
// Define NDF_BUSY_TMO_EN to add a saturating busy timeout (TMO_W bits) to the BUSY register read.
module ndf_epp_bridge
   import ndf_pkg::*;
#(
   parameter int NUM_CE = 2,
   parameter int T_WP   = 1,
   parameter int T_WH   = 1,
   parameter int T_RP   = 2
`ifdef NDF_BUSY_TMO_EN
   ,
   parameter int TMO_W  = 16
`endif
) (
   input  logic              clk10,
   input  logic              rst_n,
   input  logic              epp_astb_n,
   input  logic              epp_dstb_n,
   input  logic              epp_wr_n,
   inout  wire  [7:0]        epp_dq,
   output logic              epp_wait_n,
   inout  wire  [7:0]        ndf_io,
   output logic [NUM_CE-1:0] ndf_ce_n,
   output logic              ndf_cle,
   output logic              ndf_ale,
   output logic              ndf_we_n,
   output logic              ndf_re_n,
   output logic              ndf_wp_n,
   input  logic              ndf_r_b_n
);

   localparam int CW = $clog2(max3(T_WP, T_WH, T_RP)) + 1;

   logic              astb_n_s, dstb_n_s, wr_n_s, r_b_n_s;
   logic [7:0]        epp_d_s;
   state_t            state, state_nxt;
   logic [CW-1:0]     cnt;
   logic [7:0]        curad, curad_nxt;
   logic [7:0]        epp_q, epp_q_nxt;
   logic [7:0]        io_w, io_w_nxt;
   logic [NUM_CE-1:0] ce_n_nxt;
   logic              cle_nxt, ale_nxt, we_n_nxt, re_n_nxt, wp_n_nxt, wait_n_nxt;
   logic [8:0]        op;
   logic              tmo_hit;

   epp_sync u_sync (
      .clk10    (clk10),
      .rst_n    (rst_n),
      .astb_n   (epp_astb_n),
      .dstb_n   (epp_dstb_n),
      .wr_n     (epp_wr_n),
      .d        (epp_dq),
      .r_b_n    (ndf_r_b_n),
      .astb_n_s (astb_n_s),
      .dstb_n_s (dstb_n_s),
      .wr_n_s   (wr_n_s),
      .d_s      (epp_d_s),
      .r_b_n_s  (r_b_n_s)
   );

   assign epp_dq = wr_n_s   ? epp_q : 8'hzz;
   assign ndf_io = ndf_re_n ? io_w  : 8'hzz;
   assign op     = {wr_n_s, curad};

`ifdef NDF_BUSY_TMO_EN
   logic [TMO_W-1:0] tmo_cnt;

   // Held at zero outside BUSY, so every BUSY visit starts counting from zero.
   always_ff @(posedge clk10 or negedge rst_n) begin
      if (!rst_n)
         tmo_cnt <= '0;
      else if (state != BUSY)
         tmo_cnt <= '0;
      else if (!(&tmo_cnt))
         tmo_cnt <= tmo_cnt + 1'b1;
   end

   assign tmo_hit = (&tmo_cnt) && !r_b_n_s;
`else
   assign tmo_hit = 1'b0;
`endif

   // State register plus the shared strobe-width down-counter, loaded on state entry.
   always_ff @(posedge clk10 or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         if (state_nxt != state) begin
            case (state_nxt)
               WE_LO:   cnt <= CW'(T_WP - 1);
               WE_HI:   cnt <= CW'(T_WH - 1);
               RE_LO:   cnt <= CW'(T_RP - 1);
               default: cnt <= '0;
            endcase
         end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     if (!dstb_n_s && astb_n_s) state_nxt = DISPATCH;
         DISPATCH: begin
            case (op)
               {1'b0, REG_CMD},
               {1'b0, REG_ADDR},
               {1'b0, REG_WDATA}: state_nxt = WE_LO;
               {1'b1, REG_DATA}:  state_nxt = RE_LO;
               {1'b1, REG_BUSY}:  state_nxt = BUSY;
               default:           state_nxt = ACK;
            endcase
         end
         WE_LO:    if (cnt == '0) state_nxt = WE_HI;
         WE_HI:    if (cnt == '0) state_nxt = ACK;
         RE_LO:    if (cnt == '0) state_nxt = ACK;
         BUSY: begin
            if (dstb_n_s)               state_nxt = IDLE;
            else if (r_b_n_s || tmo_hit) state_nxt = ACK;
         end
         ACK:      if (dstb_n_s) state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   // Next values for every pin-facing register; the pins themselves are flops below.
   always_comb begin
      // NOTE: every output gets a default before any branch, so no path can infer a latch.
      curad_nxt  = curad;
      epp_q_nxt  = epp_q;
      io_w_nxt   = io_w;
      ce_n_nxt   = ndf_ce_n;
      wp_n_nxt   = ndf_wp_n;
      cle_nxt    = ndf_cle;
      ale_nxt    = ndf_ale;
      re_n_nxt   = ndf_re_n;
      we_n_nxt   = (state_nxt != WE_LO);
      wait_n_nxt = 1'b0;

      if (!astb_n_s && !wr_n_s) curad_nxt = epp_d_s;

      case (state)
         DISPATCH: begin
            case (op)
               {1'b0, REG_CMD}:   begin cle_nxt = 1'b1; io_w_nxt = epp_d_s; end
               {1'b0, REG_ADDR}:  begin ale_nxt = 1'b1; io_w_nxt = epp_d_s; end
               {1'b0, REG_WDATA}: io_w_nxt = epp_d_s;
               {1'b1, REG_DATA}:  re_n_nxt = 1'b0;
               {1'b1, REG_BUSY}:  ;
               {1'b0, REG_CE}:    ce_n_nxt = ~epp_d_s[NUM_CE-1:0];
               {1'b0, REG_WP}:    wp_n_nxt = epp_d_s[0];
               default:           if (wr_n_s) epp_q_nxt = 8'hFF;
            endcase
         end
         RE_LO: if (cnt == '0) epp_q_nxt = ndf_io;
         BUSY:  epp_q_nxt = tmo_hit ? TMO_CODE : {8{r_b_n_s}};
         default: ;
      endcase

      if (state_nxt == IDLE) begin
         cle_nxt  = 1'b0;
         ale_nxt  = 1'b0;
         re_n_nxt = 1'b1;
      end

      case (state_nxt)
         ACK:     wait_n_nxt = 1'b1;
         BUSY:    wait_n_nxt = r_b_n_s;
         IDLE:    wait_n_nxt = !astb_n_s;
         default: wait_n_nxt = 1'b0;
      endcase
   end

   always_ff @(posedge clk10 or negedge rst_n) begin
      if (!rst_n) begin
         curad      <= 8'h00;
         epp_q      <= 8'h00;
         io_w       <= 8'h00;
         ndf_ce_n   <= '1;
         ndf_wp_n   <= 1'b0;
         ndf_cle    <= 1'b0;
         ndf_ale    <= 1'b0;
         ndf_we_n   <= 1'b1;
         ndf_re_n   <= 1'b1;
         epp_wait_n <= 1'b0;
      end else begin
         curad      <= curad_nxt;
         epp_q      <= epp_q_nxt;
         io_w       <= io_w_nxt;
         ndf_ce_n   <= ce_n_nxt;
         ndf_wp_n   <= wp_n_nxt;
         ndf_cle    <= cle_nxt;
         ndf_ale    <= ale_nxt;
         ndf_we_n   <= we_n_nxt;
         ndf_re_n   <= re_n_nxt;
         epp_wait_n <= wait_n_nxt;
      end
   end

endmodule
